// File: rtl/zap_gpio_pkg.sv
// zap_gpio_pkg: register offsets, window size and byte-lane helper for zap_gpio_out
package zap_gpio_pkg;
  localparam logic [4:0] GPIO_DATA_OFF       = 5'h00;
  localparam logic [4:0] GPIO_SET_OFF        = 5'h04;
  localparam logic [4:0] GPIO_CLR_OFF        = 5'h08;
  localparam logic [4:0] GPIO_TGL_OFF        = 5'h0C;
  localparam logic [4:0] GPIO_BLINK_MASK_OFF = 5'h10;
  localparam logic [4:0] GPIO_PERIOD_OFF     = 5'h14;
  localparam logic [31:0] GPIO_WINDOW        = 32'd24;
  function automatic logic [31:0] ben_mask(input logic [3:0] ben);
    return {{8{ben[3]}}, {8{ben[2]}}, {8{ben[1]}}, {8{ben[0]}}};
  endfunction
endpackage

// File: rtl/zap_gpio_blink_timer.sv
// zap_gpio_blink_timer: free-running counter that pulses tick every period+1 cycles while enabled
module zap_gpio_blink_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_clear,
  output logic                o_tick
);
  logic [PERIOD_W-1:0] cnt;
  assign o_tick = i_enable && cnt == i_period;
  always_ff @(posedge i_clk)
    cnt <= (i_reset || i_clear || !i_enable || o_tick) ? '0 : cnt + PERIOD_W'(1);
endmodule

// File: rtl/zap_gpio_out.sv
// zap_gpio_out: memory-mapped GPIO output register with set/clr/tgl aliases; blink engine built only with ZAP_GPIO_BLINK_EN
module zap_gpio_out
  import zap_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd6000,
  parameter int          CHANNELS  = 8,
  parameter int          PERIOD_W  = 24
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [31:0]         i_address,
  input  logic                i_wr_en,
  input  logic                i_rd_en,
  input  logic [31:0]         i_wr_data,
  input  logic [3:0]          i_ben,
  output logic [31:0]         o_rd_data,
  output logic                o_rd_valid,
  output logic [CHANNELS-1:0] o_gpio
);
  logic [31:0] off, lanes, w, rd_word;
  logic hit, wr, rd, tick, unused_bits;
  logic [CHANNELS-1:0] data, mask, bus, lane_c, w_c;
  logic [PERIOD_W-1:0] period;
  assign off = i_address - BASE_ADDR;
  assign hit = off < GPIO_WINDOW && off[1:0] == 2'b00;
  assign wr = hit && i_wr_en;
  assign rd = hit && i_rd_en;
  assign lanes = ben_mask(i_ben);
  assign w = i_wr_data & lanes;
  assign lane_c = lanes[CHANNELS-1:0];
  assign w_c = w[CHANNELS-1:0];
  assign unused_bits = ^{lanes, w};
  assign bus = !wr ? data :
               off[4:0] == GPIO_DATA_OFF ? (data & ~lane_c) | w_c :
               off[4:0] == GPIO_SET_OFF  ? data | w_c :
               off[4:0] == GPIO_CLR_OFF  ? data & ~w_c :
               off[4:0] == GPIO_TGL_OFF  ? data ^ w_c : data;
  assign rd_word = off[4:0] == GPIO_BLINK_MASK_OFF ? 32'(mask) :
                   off[4:0] == GPIO_PERIOD_OFF     ? 32'(period) : 32'(data);
`ifdef ZAP_GPIO_BLINK_EN
  always_ff @(posedge i_clk)
    if (i_reset) begin
      mask   <= '0;
      period <= '0;
    end else if (wr) begin
      if (off[4:0] == GPIO_BLINK_MASK_OFF) mask <= (mask & ~lane_c) | w_c;
      if (off[4:0] == GPIO_PERIOD_OFF) period <= (period & ~lanes[PERIOD_W-1:0]) | w[PERIOD_W-1:0];
    end
  zap_gpio_blink_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (period != '0 && mask != '0),
    .i_period (period),
    .i_clear  (wr && off[4:0] == GPIO_PERIOD_OFF && |i_ben),
    .o_tick   (tick)
  );
`else
  assign mask   = '0;
  assign period = '0;
  assign tick   = 1'b0;
`endif
  always_ff @(posedge i_clk)
    if (i_reset) begin
      data       <= '0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      data       <= bus ^ (tick ? mask : '0);
      o_rd_valid <= rd;
      if (rd) o_rd_data <= rd_word;
    end
  assign o_gpio = data;
endmodule

// File: tb/tb_zap_gpio_out.sv
// tb_zap_gpio_out: directed plus random bus traffic checked against a register-level reference model
module tb_zap_gpio_out;
  localparam logic [31:0] BASE = 32'd6000;
`ifdef ZAP_GPIO_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  localparam logic [31:0] CH_M  = 32'h0000_00FF;
  localparam logic [31:0] PER_M = 32'h00FF_FFFF;
  logic clk = 1'b0;
  logic rst, wr_en, rd_en, rd_valid;
  logic [31:0] addr, wdata, rd_data;
  logic [3:0] ben;
  logic [7:0] gpio;
  int n_vec = 0, n_err = 0;
  logic [31:0] m_data, m_mask, m_per, m_rd;
  logic m_valid;
  int m_cnt;
  always #5 clk = ~clk;
  zap_gpio_out dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_address  (addr),
    .i_wr_en    (wr_en),
    .i_rd_en    (rd_en),
    .i_wr_data  (wdata),
    .i_ben      (ben),
    .o_rd_data  (rd_data),
    .o_rd_valid (rd_valid),
    .o_gpio     (gpio)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic [31:0] a, input logic we, input logic re,
                      input logic [31:0] d, input logic [3:0] b);
    logic [31:0] off, lm, w, bus, old_mask;
    logic hit, tick;
    int o;
    rst = r; addr = a; wr_en = we; rd_en = re; wdata = d; ben = b;
    off = a - BASE;
    hit = off < 32'd24 && off % 4 == 0;
    o = int'(off);
    lm = 0;
    for (int k = 0; k < 4; k++) if (b[k]) lm |= 32'hFF << (8 * k);
    w = d & lm;
    if (r) begin
      m_data = 0; m_mask = 0; m_per = 0; m_cnt = 0; m_valid = 0; m_rd = 0;
    end else begin
      tick = BLINK && m_per != 0 && m_mask != 0 && m_cnt == int'(m_per);
      old_mask = m_mask;
      m_valid = hit && re;
      if (m_valid) m_rd = (o == 16) ? m_mask : (o == 20) ? m_per : m_data;
      m_cnt = (BLINK && m_per != 0 && m_mask != 0 && !tick) ? m_cnt + 1 : 0;
      bus = m_data;
      if (hit && we) begin
        case (o)
          0:  bus = (m_data & ~lm) | w;
          4:  bus = m_data | w;
          8:  bus = m_data & ~w;
          12: bus = m_data ^ w;
          16: if (BLINK) m_mask = ((m_mask & ~lm) | w) & CH_M;
          20: if (BLINK) begin
                m_per = ((m_per & ~lm) | w) & PER_M;
                if (b != 0) m_cnt = 0;
              end
          default: ;
        endcase
      end
      m_data = (bus ^ (tick ? old_mask : 32'd0)) & CH_M;
    end
    @(posedge clk);
    #1;
    chk("gpio", 32'(gpio), m_data);
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("rd_data", rd_data, m_rd);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, BASE + 32'h40, 0, 0, 0, 0);
  endtask
  initial begin
    logic [31:0] a, d;
    int sel;
    #2;
    step(1, 0, 0, 0, 0, 0);
    step(1, BASE, 1, 1, 32'hFFFF_FFFF, 4'hF);
    step(0, BASE, 0, 1, 0, 0);
    chk("reset_read", rd_data, 32'd0);
    step(0, BASE, 1, 0, 32'h0000_00A5, 4'b0001);
    chk("plan_data", 32'(gpio), 32'hA5);
    step(0, BASE + 4, 1, 0, 32'h0F, 4'hF);
    chk("plan_set", 32'(gpio), 32'hAF);
    step(0, BASE + 8, 1, 0, 32'h81, 4'hF);
    chk("plan_clr", 32'(gpio), 32'h2E);
    step(0, BASE + 12, 1, 0, 32'hFF, 4'hF);
    chk("plan_tgl", 32'(gpio), 32'hD1);
    step(0, BASE, 1, 0, 32'hFFFF_FFFF, 4'b0010);
    chk("ben_upper", 32'(gpio), 32'hD1);
    step(0, BASE + 4, 0, 1, 0, 0);
    step(0, BASE + 12, 1, 1, 32'h0F, 4'hF);
    step(0, BASE + 32'h18, 1, 1, 32'hFF, 4'hF);
    step(0, BASE + 2, 1, 1, 32'hFF, 4'hF);
    step(0, BASE - 4, 1, 1, 32'hFF, 4'hF);
    step(0, BASE + 20, 1, 0, 32'd3, 4'hF);
    step(0, BASE + 16, 1, 0, 32'h01, 4'hF);
    step(0, BASE + 16, 0, 1, 0, 0);
    step(0, BASE + 20, 0, 1, 0, 0);
    idle(12);
    for (int i = 0; i < 10 && !(m_per != 0 && m_mask != 0 && m_cnt == int'(m_per)); i++) idle(1);
    step(0, BASE + 12, 1, 0, 32'h01, 4'hF);
    idle(3);
    step(0, BASE + 20, 1, 0, 32'd1, 4'b0001);
    idle(6);
    step(1, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 8);
      a = sel < 6 ? BASE + 32'(4 * sel) : sel == 6 ? BASE + 32'h18 : sel == 7 ? BASE + 2 : $urandom;
      d = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 7)) : $urandom;
      step($urandom_range(0, 99) == 0, a, 1'($urandom), 1'($urandom), d, 4'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/zap_gpio_out.md
# zap_gpio_out

Memory-mapped, parametrised GPIO output controller for ZAP SoCs. It replaces the single-bit LED latch at data address 6000 with a CHANNELS-wide output register. The register has atomic set, clear and toggle aliases, byte-enable-aware writes, registered readback, and an optional per-channel hardware blink engine. It sits on the core's data port (address, write enable, write data, byte enables) next to the SRAM, and drives board LEDs or pins directly from flops.

## Interface
Parameters:
- BASE_ADDR, 32'd6000: byte address of register 0. Must be word aligned.
- CHANNELS, 8: number of output bits, 1..32.
- PERIOD_W, 24: width of the blink period register and counter, 1..32.

Ports:
- i_clk  in  1  clock. All state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_address  in  32  data byte address from the core.
- i_wr_en  in  1  store strobe, qualified by address hit.
- i_rd_en  in  1  load strobe, qualified by address hit.
- i_wr_data  in  32  store data.
- i_ben  in  4  byte enables; bit k covers i_wr_data[8k+7:8k].
- o_rd_data  out  32  registered read data.
- o_rd_valid  out  1  read data valid, one-cycle pulse.
- o_gpio  out  CHANNELS  output pins, driven directly from the DATA register.

## Operation
- Hit condition: off = i_address − BASE_ADDR (32-bit unsigned) < 24 and off[1:0] == 0. Any other address is ignored.
- Register map (byte offset):
  - 0x00 DATA: read/write.
  - 0x04 SET: write-1-to-set.
  - 0x08 CLR: write-1-to-clear.
  - 0x0C TGL: write-1-to-toggle.
  - 0x10 BLINK_MASK: read/write.
  - 0x14 PERIOD: read/write.
- Effective write mask: w = i_wr_data with each byte lane whose i_ben bit is 0 forced to 0. Bits at or above CHANNELS (PERIOD_W for PERIOD) are ignored.
- Write effects, applied only to bits whose byte lane is enabled:
  - DATA write replaces the enabled bits.
  - SET: DATA |= w.
  - CLR: DATA &= ~w.
  - TGL: DATA ^= w.
  - BLINK_MASK and PERIOD behave like DATA.
- Blink engine: the counter advances only while PERIOD != 0 and BLINK_MASK != 0.
  - tick is asserted when counter == PERIOD; on tick the counter returns to 0.
  - Otherwise the counter increments by 1.
  - In all other cases (engine idle) the counter holds 0.
  - A toggle of a masked bit therefore occurs every PERIOD+1 cycles.
- Simultaneous events, DATA next state:
  - DATA_next = bus_result ^ (tick ? BLINK_MASK : 0), where bus_result is DATA after the bus write.
  - The blink mask used is the value before any same-cycle write to BLINK_MASK.
  - A write to PERIOD (any enabled lane) clears the counter; it does not suppress a same-cycle tick.
- Reads:
  - SET, CLR and TGL read back DATA. Unused upper bits read 0.
  - A read without a hit produces o_rd_valid = 0 and leaves o_rd_data unchanged.
- i_rd_en and i_wr_en asserted together on a hit: the write is performed, and the read returns the pre-write value.

## Timing
- Reset values: DATA, BLINK_MASK, PERIOD, counter, o_gpio, o_rd_data and o_rd_valid are all 0.
- Write to o_gpio latency: 1 cycle. The value is visible on o_gpio after the rising edge that samples i_wr_en.
- Read latency: 1 cycle. o_rd_valid is high for exactly one cycle. Back-to-back reads are accepted every cycle; there is no backpressure and no stall output.
- Reset asserted mid-blink: all state returns to 0 on that edge, and there is no tick in that cycle.
- Counter wrap: the counter never exceeds PERIOD. Writing a PERIOD smaller than the current count is safe because the write clears the counter.

## Configuration
- ZAP_GPIO_BLINK_EN defined:
  - The blink engine, BLINK_MASK and PERIOD are implemented as described above.
- ZAP_GPIO_BLINK_EN undefined:
  - BLINK_MASK and PERIOD read as 0 and writes to them are ignored.
  - There is no counter logic and tick is held at 0.
  - Offsets 0x10 and 0x14 still hit, so o_rd_valid behaviour is unchanged.

## Structure
- Package zap_gpio_pkg holds:
  - the register offset localparams (GPIO_DATA_OFF … GPIO_PERIOD_OFF);
  - the register window size (24);
  - a byte-lane mask helper function.
- Sub-module zap_gpio_blink_timer contains the PERIOD_W counter and tick generation. Inputs: enable, period, clear. Output: tick. It is instantiated only under ZAP_GPIO_BLINK_EN.

## Test plan
- Reset, then read DATA: o_rd_valid pulses 1 cycle later with o_rd_data = 0, and o_gpio = 0.
- Write DATA = 0xA5 with i_ben = 4'b0001, then SET 0x0F, then CLR 0x81, then TGL 0xFF: o_gpio reads 0xA5, then 0xAF, then 0x2E, then 0xD1.
- Write DATA = 0xFFFFFFFF with i_ben = 4'b0010: DATA is unchanged (bits 8..31 are beyond CHANNELS = 8).
- Write PERIOD = 3 and BLINK_MASK = 0x01: bit 0 toggles every 4 cycles, and other bits are static.
- Issue a TGL 0x01 write in the same cycle as a tick: the bit is unchanged (double toggle).
- Issue a read or write at BASE_ADDR + 0x18, or at BASE_ADDR + 2: there is no state change and o_rd_valid stays 0.
